px_ram_sp_ctrl: RTL and testbench

PX_RAM_SP_CTRL -- requirements
Module: px_ram_sp_ctrl

---
 rtl/px_ram_sp_ctrl_if.sv | 24 ++
 rtl/px_ram_sp_ctrl.sv | 140 ++++++++++++++
 tb/tb_px_ram_sp_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/px_ram_sp_ctrl_if.sv
// Request/response bus between a client (master) and px_ram_sp_ctrl (slave).
interface px_ram_sp_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) ();
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/px_ram_sp_ctrl.sv
// Single-port RAM controller: credit-limited request path, 3-entry in-order read FIFO.
// Define PX_RAM_SP_CTRL_INIT_EN to zero the whole RAM after reset before accepting requests.
module px_ram_sp_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    px_ram_sp_ctrl_if.slave       bus,
    output logic                  ram_ena,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  init_done
);

    logic                  in_run;
    logic                  init_active;
    logic [ADDR_WIDTH-1:0] init_addr;

`ifdef PX_RAM_SP_CTRL_INIT_EN
    typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == '1) state_d = ST_RUN;
        end
    end

    always_comb begin
        in_run      = (state_q == ST_RUN);
        init_active = (state_q == ST_INIT);
        init_addr   = init_cnt_q;
        init_done   = in_run;
    end
`else
    always_comb begin
        in_run      = 1'b1;
        init_active = 1'b0;
        init_addr   = '0;
        init_done   = 1'b1;
    end
`endif

    logic [DATA_WIDTH-1:0] fifo_q [3];
    logic [DATA_WIDTH-1:0] fifo_d [3];
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  pending_q, pending_d;
    logic [2:0]            used;
    logic                  accept;
    logic                  push;
    logic                  pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    // Credits count buffered plus in-flight reads, so a push never meets a full FIFO.
    always_comb begin
        used          = {1'b0, count_q} + {2'b00, pending_q};
        bus.req_ready = rst_n && in_run && (used < 3'd3);
        bus.rsp_valid = rst_n && (count_q != 2'd0);
        bus.rsp_rdata = bus.rsp_valid ? fifo_q[rd_ptr_q] : '0;
        accept        = bus.req_valid && bus.req_ready;
        push          = pending_q;
        pop           = bus.rsp_valid && bus.rsp_ready;
    end

    always_comb begin
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        pending_d = accept && !bus.req_wr;
        if (push) begin
            fifo_d[wr_ptr_q] = ram_rdata;
            wr_ptr_d         = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // RAM port is combinational so the RAM samples on the acceptance edge; reset masks it.
    always_comb begin
        ram_ena   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_n) begin
            if (init_active) begin
                ram_ena  = 1'b1;
                ram_wen  = 1'b1;
                ram_addr = init_addr;
            end else begin
                ram_ena   = accept;
                ram_wen   = bus.req_wr;
                ram_addr  = bus.req_addr;
                ram_wdata = bus.req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_px_ram_sp_ctrl.sv
// Randomized bench for px_ram_sp_ctrl against a timestamped response-queue model.
module tb_px_ram_sp_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef PX_RAM_SP_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    px_ram_sp_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic          ram_ena, ram_wen, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    px_ram_sp_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_ena   (ram_ena),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
    );

    // Single-port RAM with registered read data.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_ena) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_wdata;
            else         ram_rdata         <= ram_mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: each outstanding read is one entry, visible two cycles after acceptance.
    typedef struct {
        logic [DW-1:0] d;
        int unsigned   at;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    bit            written [DEPTH];
    bit            run_m;
    int unsigned   init_k;
    int unsigned   cyc;

    task automatic step(input bit v, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input bit rr);
        bit rdy_e, acc, vld_e;
        bus.req_valid = v;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.rsp_ready = rr;
        #1;
        rdy_e = run_m && (exp_q.size() < 3);
        acc   = v && rdy_e;
        vld_e = (exp_q.size() > 0) && (exp_q[0].at <= cyc);
        check_eq("req_ready", bus.req_ready, rdy_e);
        check_eq("init_done", init_done, run_m);
        if (!run_m) begin
            check_eq("init_ena", ram_ena, 1);
            check_eq("init_wen", ram_wen, 1);
            check_eq("init_addr", ram_addr, init_k);
            check_eq("init_wdata", ram_wdata, 0);
        end else begin
            check_eq("ram_ena", ram_ena, acc);
            if (acc) begin
                check_eq("ram_wen", ram_wen, wr);
                check_eq("ram_addr", ram_addr, a);
                check_eq("ram_wdata", ram_wdata, wd);
            end
        end
        check_eq("rsp_valid", bus.rsp_valid, vld_e);
        if (vld_e) check_eq("rsp_rdata", bus.rsp_rdata, exp_q[0].d);
        if (vld_e && rr) void'(exp_q.pop_front());
        if (acc) begin
            if (wr) begin
                ref_mem[a] = wd;
                written[a] = 1'b1;
            end else begin
                exp_q.push_back('{d: ref_mem[a], at: cyc + 2});
            end
        end
        if (!run_m) begin
            init_k++;
            if (init_k == DEPTH) run_m = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_step(input int unsigned rr_pct);
        logic [AW-1:0] a;
        bit            wr;
        a  = AW'($urandom_range(0, DEPTH - 1));
        wr = bit'($urandom_range(0, 1));
        if (!written[a]) wr = 1'b1;
        step($urandom_range(0, 99) < 70, wr, a, DW'($urandom), $urandom_range(0, 99) < rr_pct);
    endtask

    // Entered at a negedge; asserts reset mid-cycle and releases it on a later negedge.
    task automatic do_reset(input int unsigned cycles);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = AW'(5);
        bus.req_wdata = 8'hFF;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", bus.req_ready, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
        check_eq("rst_ram_ena", ram_ena, 0);
        check_eq("rst_ram_wen", ram_wen, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        exp_q.delete();
        repeat (cycles) @(negedge clk);
        rst_n  = 1'b1;
        run_m  = !INIT_EN;
        init_k = 0;
        if (INIT_EN) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i] = '0;
                written[i] = 1'b1;
            end
        end
    endtask

    task automatic run_init();
        if (INIT_EN) repeat (DEPTH) rand_step(50);
    endtask

    task automatic drain();
        repeat (6) step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        cyc = 0;
        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

        @(negedge clk);
        do_reset(3);
        run_init();

        // Write then read back the same address.
        step(1'b1, 1'b1, AW'(3), 8'hA5, 1'b1);
        step(1'b1, 1'b0, AW'(3), 8'h00, 1'b1);
        drain();

        // Back-to-back reads at full throughput.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, AW'(i), DW'(i + 8'h10), 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, AW'(i), 8'h00, 1'b1);
        drain();

        // Backpressure: credits run out after three reads, then drain in order.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, AW'(i), 8'h00, 1'b0);
        repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
        drain();

        repeat (150) rand_step(100);
        repeat (150) rand_step(50);
        repeat (150) rand_step(15);
        drain();

        // Reset with two responses buffered and one read in flight.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, AW'(i + 4), 8'h00, 1'b0);
        do_reset(2);
        if (INIT_EN) begin
            repeat (5) rand_step(50);
            do_reset(2);
        end
        run_init();
        repeat (5) step(1'b0, 1'b0, '0, '0, 1'b1);
        repeat (100) rand_step(60);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
